// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - shares one combinational ALU between two requesters.
// Define ALU_SHARE_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module alu_share_ctrl #(
    parameter int WIDTH   = 21,
    parameter int OPW     = 5,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    input  logic             alu_z
);
    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = $clog2(MAXL + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
    logic             rsp0_zero_q, rsp0_zero_d, rsp1_zero_q, rsp1_zero_d;
    logic             grant0, grant1, accept, pick1, rsp_done;
    logic [OPW-1:0]   acc_op;

`ifdef ALU_SHARE_RR_EN
    // ptr holds the port granted last; the other port wins a tie.
    logic ptr_q, ptr_d;
    assign pick1 = ~ptr_q;
`else
    assign pick1 = 1'b0;
`endif

    assign grant0   = req0_valid & ~(req1_valid & pick1);
    assign grant1   = req1_valid & (~req0_valid | pick1);
    assign accept   = (state_q == IDLE) & (grant0 | grant1);
    assign acc_op   = grant1 ? req1_op : req0_op;
    assign rsp_done = (state_q == RESP) & (owner_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp0_data_q <= '0;
            rsp0_zero_q <= 1'b0;
            rsp1_data_q <= '0;
            rsp1_zero_q <= 1'b0;
`ifdef ALU_SHARE_RR_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp0_data_q <= rsp0_data_d;
            rsp0_zero_q <= rsp0_zero_d;
            rsp1_data_q <= rsp1_data_d;
            rsp1_zero_q <= rsp1_zero_d;
`ifdef ALU_SHARE_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    if (cnt_q == CW'(1)) state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp0_data_d = rsp0_data_q;
        rsp0_zero_d = rsp0_zero_q;
        rsp1_data_d = rsp1_data_q;
        rsp1_zero_d = rsp1_zero_q;
`ifdef ALU_SHARE_RR_EN
        ptr_d       = ptr_q;
`endif
        if (accept) begin
            owner_d   = grant1;
            alu_a_d   = grant1 ? req1_a : req0_a;
            alu_b_d   = grant1 ? req1_b : req0_b;
            alu_sel_d = acc_op;
            if (acc_op == OPW'(5'b01001))      cnt_d = CW'(MUL_LAT);
            else if (acc_op == OPW'(5'b01010)) cnt_d = CW'(DIV_LAT);
            else                               cnt_d = CW'(1);
`ifdef ALU_SHARE_RR_EN
            ptr_d     = grant1;
`endif
        end
        if (state_q == EXEC) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                if (owner_q) begin
                    rsp1_data_d = alu_c;
                    rsp1_zero_d = alu_z;
                end else begin
                    rsp0_data_d = alu_c;
                    rsp0_zero_d = alu_z;
                end
            end
        end
    end

    always_comb begin
        req0_ready = (state_q == IDLE) & grant0;
        req1_ready = (state_q == IDLE) & grant1;
        rsp0_valid = (state_q == RESP) & ~owner_q;
        rsp1_valid = (state_q == RESP) & owner_q;
    end

    assign rsp0_data = rsp0_data_q;
    assign rsp0_zero = rsp0_zero_q;
    assign rsp1_data = rsp1_data_q;
    assign rsp1_zero = rsp1_zero_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl with a behavioural ALU.
module tb_alu_share_ctrl;
    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [4:0]   req0_op = 0, req1_op = 0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 0, rsp1_ready = 0;
    logic [W-1:0] rsp0_data, rsp1_data;
    logic         rsp0_zero, rsp1_zero;
    logic [W-1:0] alu_a, alu_b, alu_c;
    logic [4:0]   alu_sel;
    logic         alu_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c), .alu_z(alu_z)
    );

    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
        case (op)
            5'b00011: return a + b;
            5'b00101: return a - b;
            5'b01001: return a * b;
            5'b01010: return (b == 0) ? {W{1'b1}} : a / b;
            default:  return a & b;
        endcase
    endfunction

    function automatic int cycles_to_rsp(input logic [4:0] op);
        if (op == 5'b01001) return 2 + 1;
        if (op == 5'b01010) return 4 + 1;
        return 1 + 1;
    endfunction

    always_comb begin
        alu_c = alu_ref(alu_a, alu_b, alu_sel);
        alu_z = (alu_c == '0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic rv(input int p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic do_op(input string nm, input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] op, input logic [W-1:0] ed, input logic ez, input int ecyc, input int rdly);
        logic [W-1:0] od;
        logic         oz;
        int           n;
        bit           got;
        od = port ? rsp0_data : rsp1_data;
        oz = port ? rsp0_zero : rsp1_zero;
        @(negedge clk);
        if (port) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
        else      begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
        n = 0; got = 0;
        while (!got && n < 20) begin
            #1;
            if (port ? req1_ready : req0_ready) got = 1;
            else begin @(negedge clk); n++; end
        end
        chk({nm, "_accept"}, 32'(got), 32'd1);
        if (got) @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        if (!got) return;
        n = 1;
        while (!rv(port) && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_lat"}, 32'(n), 32'(ecyc));
        chk({nm, "_data"}, 32'(port ? rsp1_data : rsp0_data), 32'(ed));
        chk({nm, "_zero"}, 32'(port ? rsp1_zero : rsp0_zero), 32'(ez));
        chk({nm, "_other"}, {10'd0, rv(1 - port), port ? rsp0_zero : rsp1_zero, port ? rsp0_data : rsp1_data},
            {10'd0, 1'b0, oz, od});
        repeat (rdly) begin
            @(negedge clk);
            chk({nm, "_hold"}, {10'd0, rv(port), port ? rsp1_data : rsp0_data}, {10'd0, 1'b1, ed});
        end
        if (port) rsp1_ready = 1; else rsp0_ready = 1;
        @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        chk({nm, "_done"}, 32'(rv(port)), 32'd0);
    endtask

    typedef struct {
        int         port;
        logic [W-1:0] a, b;
        logic [4:0] op;
        logic [W-1:0] d;
        logic       z;
        int         cyc;
    } vec_t;

    vec_t vecs[6];
    int   grants[$];
    int   exp_g[4];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hits;
        logic [4:0] ops[5];
        vecs[0] = '{0, 21'd5,       21'd10,       5'b00011, 21'd15,   1'b0, 2};
        vecs[1] = '{0, 21'd3,       21'd7,        5'b01001, 21'd21,   1'b0, 3};
        vecs[2] = '{0, 21'd20,      21'd4,        5'b01010, 21'd5,    1'b0, 5};
        vecs[3] = '{1, 21'h000005,  21'h1FFFFB,   5'b00011, 21'd0,    1'b1, 2};
        vecs[4] = '{1, 21'd10,      21'd3,        5'b00101, 21'd7,    1'b0, 2};
        vecs[5] = '{0, 21'h0000F0,  21'h00003C,   5'b11111, 21'h30,   1'b0, 2};
`ifdef ALU_SHARE_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        ops = '{5'b00011, 5'b00101, 5'b01001, 5'b01010, 5'b10110};

        repeat (2) @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'b01);
        @(negedge clk);
        rst = 0; req0_valid = 0; req1_valid = 0;
        #1;
        chk("rst_rsp", {rsp1_valid, rsp0_valid, rsp1_zero, rsp0_zero}, 32'd0);
        chk("rst_data", {11'd0, rsp0_data | rsp1_data}, 32'd0);
        chk("rst_alu", {6'd0, alu_sel, alu_a | alu_b}, 32'd0);

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op,
                  vecs[i].d, vecs[i].z, vecs[i].cyc, i % 3);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            logic [4:0]   op;
            a  = W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? W'(-a) : W'($urandom_range(0, 4000));
            op = ops[$urandom_range(0, 4)];
            do_op($sformatf("rnd%0d", i), int'($urandom_range(0, 1)), a, b, op,
                  alu_ref(a, b, op), alu_ref(a, b, op) == 0, cycles_to_rsp(op), int'($urandom_range(0, 3)));
        end

        do_reset();
        @(negedge clk);
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 1; req0_b = 2; req0_op = 5'b00011;
        req1_a = 3; req1_b = 4; req1_op = 5'b00011;
        n = 0;
        while (grants.size() < 4 && n < 60) begin
            #1;
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            @(negedge clk); n++;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (6) @(negedge clk);
        rsp0_ready = 0; rsp1_ready = 0;
        chk("arb_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("arb_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'hFF, 32'(exp_g[i]));

        @(negedge clk);
        req0_valid = 1; req0_a = 7; req0_b = 8; req0_op = 5'b00011;
        n = 0;
        while (n < 20) begin #1; if (req0_ready) break; @(negedge clk); n++; end
        chk("bp_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        req0_valid = 0;
        n = 0;
        while (!rsp0_valid && n < 20) begin @(negedge clk); n++; end
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold%0d", i), {8'd0, req1_ready, req0_ready, rsp0_valid, rsp0_data}, {8'd0, 3'b001, 21'd15});
            @(negedge clk);
        end
        rsp0_ready = 1;
        #1;
        chk("bp_hs_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
        @(negedge clk);
        rsp0_ready = 0;
        #1;
        chk("bp_after", {9'd0, rsp0_valid, req0_ready | req1_ready, rsp0_data}, {9'd0, 2'b01, 21'd15});
        req0_valid = 0; req1_valid = 0;

        @(negedge clk);
        req0_valid = 1; req0_a = 20; req0_b = 4; req0_op = 5'b01010;
        #1;
        chk("rx_accept", 32'(req0_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rx_state", {28'd0, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 32'd0);
        chk("rx_alu", {6'd0, alu_sel, alu_a | alu_b}, 32'd0);
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) hits++;
        end
        chk("rx_no_rsp", 32'(hits), 32'd0);
        do_op("post_rst", 0, 21'd9, 21'd9, 5'b00101, 21'd0, 1'b1, 2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
